// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush,
// bubble payload on empty and an optional 2-entry skid buffer that makes
// in_ready a registered signal. Output data/valid always come straight from
// flops, so there is never a combinational path from in_data to out_data.

// Runtime checker for the handshake invariants of pipe_stage_reg.
module pipe_stage_reg_chk (
    input logic       clk,
    input logic       reset_n,
    input logic       accept,
    input logic [1:0] occupancy
);

    // A full stage must never take another entry.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(accept && (occupancy == 2'd2)));

    // Occupancy is 0, 1 or 2.
    a_occ_range: assert property (@(posedge clk) disable iff (!reset_n)
        (occupancy != 2'd3));

endmodule

module pipe_stage_reg #(
    parameter int                 DATA_W     = 96,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                 SKID       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam bit SKID_EN = (SKID != 0);

    // The state encoding is the occupancy count itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DATA_W-1:0]   main_r;
    logic [DATA_W-1:0]   main_s;
    logic [DATA_W-1:0]   skid_r;
    logic [DATA_W-1:0]   skid_s;
    logic                out_valid_r;
    logic                in_ready_r;
    logic                in_ready_s;
    logic                accept_s;
    logic                pop_s;

    // With the skid entry, in_ready comes from a flop; without it, a
    // downstream pop frees the single entry in the same cycle.
    assign in_ready_s = SKID_EN ? in_ready_r : (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign pop_s      = out_valid_r && out_ready;

    // Next-state and next-payload selection; flush overrides every other event.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = ST_EMPTY;
            main_s  = BUBBLE_VAL;
            skid_s  = BUBBLE_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_s = ST_ONE;
                        main_s  = in_data;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        main_s = in_data;
                    end else if (accept_s && SKID_EN) begin
                        state_s = ST_FULL;
                        skid_s  = in_data;
                    end else if (pop_s) begin
                        state_s = ST_EMPTY;
                        main_s  = BUBBLE_VAL;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_s = ST_ONE;
                        main_s  = skid_r;
                        skid_s  = BUBBLE_VAL;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    main_s  = BUBBLE_VAL;
                    skid_s  = BUBBLE_VAL;
                end
            endcase
        end
    end

    // State, payload and handshake flops; valid/ready are derived from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_EMPTY;
            main_r      <= BUBBLE_VAL;
            skid_r      <= BUBBLE_VAL;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            main_r      <= main_s;
            skid_r      <= skid_s;
            out_valid_r <= (state_s != ST_EMPTY);
            in_ready_r  <= (state_s != ST_FULL);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = state_r;

    pipe_stage_reg_chk u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .accept    (accept_s),
        .occupancy (state_r)
    );

endmodule
